// File: rtl/axi_ecc_pkg.sv
// Shared definitions for the AXI R-channel SECDED checker: codeword layout,
// response codes, decode result and a reference encoder.
package axi_ecc_pkg;

  localparam int CODE_W = 32;
  localparam int DATA_W = 26;
  localparam int SYN_W  = 5;

  // Bit k marks codeword index k (Hamming position k+1) as covered by syndrome bit i.
  localparam logic [CODE_W-2:0] SYN_MASK [SYN_W] = '{
    31'h5555_5555, 31'h6666_6666, 31'h7878_7878, 31'h7F80_7F80, 31'h7FFF_8000
  };

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              corr;
    logic              uncorr;
  } dec_res_t;

  function automatic logic [DATA_W-1:0] ecc_extract(input logic [CODE_W-1:0] cw);
    return {cw[30:16], cw[14:8], cw[6:4], cw[2]};
  endfunction

  function automatic logic [CODE_W-1:0] ecc_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] cw;
    cw = {1'b0, d[25:11], 1'b0, d[10:4], 1'b0, d[3:1], 1'b0, d[0], 2'b00};
    // Masks never cover another parity slot, so the parities are independent.
    cw[0]  = ^(cw[CODE_W-2:0] & SYN_MASK[0]);
    cw[1]  = ^(cw[CODE_W-2:0] & SYN_MASK[1]);
    cw[3]  = ^(cw[CODE_W-2:0] & SYN_MASK[2]);
    cw[7]  = ^(cw[CODE_W-2:0] & SYN_MASK[3]);
    cw[15] = ^(cw[CODE_W-2:0] & SYN_MASK[4]);
    cw[31] = ^cw[CODE_W-2:0];
    return cw;
  endfunction

endpackage

// File: rtl/secded_dec_26_32.sv
// Combinational SECDED decoder: 32-bit Hamming codeword to 26-bit data plus
// corrected / uncorrectable flags.
module secded_dec_26_32
  import axi_ecc_pkg::*;
(
  input  logic [CODE_W-1:0] cw,
  output logic [DATA_W-1:0] data,
  output logic              corr,
  output logic              uncorr
);

  logic [SYN_W-1:0]  syn;
  logic              ovr;
  logic [CODE_W-1:0] fixed;
  dec_res_t          res;

  for (genvar i = 0; i < SYN_W; i++) begin : g_syn
    assign syn[i] = ^(cw[CODE_W-2:0] & SYN_MASK[i]);
  end

  assign ovr = ^cw;

  always_comb begin
    fixed = cw;
    // Odd overall parity with zero syndrome means only P6 flipped: data is intact.
    if (ovr && (syn != '0))
      fixed = cw ^ ({{(CODE_W-1){1'b0}}, 1'b1} << (syn - 5'd1));
    res.data   = ecc_extract(fixed);
    res.corr   = ovr;
    res.uncorr = !ovr && (syn != '0);
  end

  assign data   = res.data;
  assign corr   = res.corr;
  assign uncorr = res.uncorr;

endmodule

// File: rtl/axi_r_ecc_chk.sv
// AXI read-data SECDED checker: one register stage between responder and master,
// with response merge, saturating error counters and a sticky interrupt.
module axi_r_ecc_chk
  import axi_ecc_pkg::*;
#(
  parameter int AXI_ID_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                aclk,
  input  logic                srst,
  input  logic                in_s_rvalid,
  output logic                out_s_rready,
  input  logic [AXI_ID_W-1:0] in_s_rid,
  input  logic [1:0]          in_s_rresp,
  input  logic [CODE_W-1:0]   in_s_rdata,
  input  logic                in_s_rlast,
  output logic                out_m_rvalid,
  input  logic                in_m_rready,
  output logic [AXI_ID_W-1:0] out_m_rid,
  output logic [1:0]          out_m_rresp,
  output logic [DATA_W-1:0]   out_m_rdata,
  output logic                out_m_rlast,
  output logic                out_m_ecc_corr,
  output logic                out_m_ecc_uncorr,
  output logic [CNT_W-1:0]    out_corr_cnt,
  output logic [CNT_W-1:0]    out_uncorr_cnt,
  input  logic                in_irq_clr,
  output logic                out_irq
);

  logic [DATA_W-1:0] dec_data;
  logic              dec_corr;
  logic              dec_uncorr;
  logic              deliver;

  secded_dec_26_32 u_dec (
    .cw     (in_s_rdata),
    .data   (dec_data),
    .corr   (dec_corr),
    .uncorr (dec_uncorr)
  );

  assign out_s_rready = !out_m_rvalid | in_m_rready;
  assign deliver      = out_m_rvalid & in_m_rready;

  always_ff @(posedge aclk) begin
    if (srst) begin
      out_m_rvalid     <= 1'b0;
      out_m_rid        <= '0;
      out_m_rresp      <= '0;
      out_m_rdata      <= '0;
      out_m_rlast      <= 1'b0;
      out_m_ecc_corr   <= 1'b0;
      out_m_ecc_uncorr <= 1'b0;
      out_corr_cnt     <= '0;
      out_uncorr_cnt   <= '0;
      out_irq          <= 1'b0;
    end else begin
      if (out_s_rready) begin
        out_m_rvalid <= in_s_rvalid;
        if (in_s_rvalid) begin
          out_m_rid        <= in_s_rid;
          out_m_rdata      <= dec_data;
          out_m_rlast      <= in_s_rlast;
          out_m_ecc_corr   <= dec_corr;
          out_m_ecc_uncorr <= dec_uncorr;
          // Only escalate a clean response; existing error codes take precedence.
          out_m_rresp      <= (dec_uncorr && in_s_rresp == RESP_OKAY) ? RESP_SLVERR : in_s_rresp;
        end
      end
      if (deliver && out_m_ecc_corr && out_corr_cnt != '1)
        out_corr_cnt <= out_corr_cnt + CNT_W'(1);
      if (deliver && out_m_ecc_uncorr && out_uncorr_cnt != '1)
        out_uncorr_cnt <= out_uncorr_cnt + CNT_W'(1);
      if (deliver && out_m_ecc_uncorr)
        out_irq <= 1'b1;
      else if (in_irq_clr)
        out_irq <= 1'b0;
    end
  end

endmodule
